// File: rtl/uart_tx_fifo_if.sv
// Byte-store and status bundle for the buffered UART transmitter.
// master = store side (MA stage / bench), slave = the transmitter itself.
interface uart_tx_fifo_if #(
    parameter int DEPTH_LOG2 = 4
);
    logic                  wr_en;
    logic [7:0]            wr_data;
    logic                  ovf_clr;
    logic                  full;
    logic [DEPTH_LOG2:0]   count;
    logic                  busy;
    logic                  overflow;
    logic                  tx;
    logic [1:0]            state_dbg;

    // wr_en is a single-cycle strobe with no ready: a store is accepted on the
    // edge where wr_en=1 and the registered full=0, otherwise it is dropped and
    // overflow is set.
    modport master (
        output wr_en, wr_data, ovf_clr,
        input  full, count, busy, overflow, tx, state_dbg
    );

    modport slave (
        input  wr_en, wr_data, ovf_clr,
        output full, count, busy, overflow, tx, state_dbg
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: circular byte FIFO feeding a start/data/stop
// serializer. tx comes straight from a flop; state is exported on state_dbg.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DEPTH_LOG2   = 4
) (
    input  logic           clk,
    input  logic           rst,
    uart_tx_fifo_if.slave  bus
);
    localparam int DEPTH  = 2 ** DEPTH_LOG2;
    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [BAUD_W-1:0]     BAUD_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0]     BAUD_ONE   = BAUD_W'(1);
    localparam logic [DEPTH_LOG2:0]   COUNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   COUNT_ONE  = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = DEPTH_LOG2'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t                state;
    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2:0]   count;
    logic                  overflow_q;
    logic [7:0]            shift;
    logic [2:0]            bit_idx;
    logic [BAUD_W-1:0]     baud_cnt;
    logic                  tx_q;

    logic full_w;
    logic push;
    logic pop;
    logic drop;

    assign full_w = (count == COUNT_FULL);
    assign push   = bus.wr_en && !full_w;
    assign drop   = bus.wr_en && full_w;
    // The serializer takes the head only from IDLE, so the frame in flight is
    // never counted in count.
    assign pop    = (state == S_IDLE) && (count != '0);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            if (push && !pop)      count <= count + COUNT_ONE;
            else if (pop && !push) count <= count - COUNT_ONE;
            // A drop on the clearing edge must stay visible, so set wins.
            if (drop)              overflow_q <= 1'b1;
            else if (bus.ovf_clr)  overflow_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            tx_q     <= 1'b1;
            shift    <= '0;
            bit_idx  <= '0;
            baud_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (count != '0) begin
                        shift    <= mem[rd_ptr];
                        tx_q     <= 1'b0;
                        baud_cnt <= '0;
                        state    <= S_START;
                    end else begin
                        tx_q <= 1'b1;
                    end
                end
                S_START: begin
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt <= '0;
                        tx_q     <= shift[0];
                        bit_idx  <= '0;
                        state    <= S_DATA;
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_ONE;
                    end
                end
                S_DATA: begin
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            tx_q  <= 1'b1;
                            state <= S_STOP;
                        end else begin
                            // shift[0] is the bit on the line; shift[1] is next.
                            tx_q    <= shift[1];
                            shift   <= {1'b0, shift[7:1]};
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_ONE;
                    end
                end
                S_STOP: begin
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt <= '0;
                        state    <= S_IDLE;
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_ONE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    tx_q  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.full      = full_w;
    assign bus.count     = count;
    assign bus.busy      = (state != S_IDLE) || (count != '0);
    assign bus.overflow  = overflow_q;
    assign bus.tx        = tx_q;
    assign bus.state_dbg = state;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with CLKS_PER_BIT=4, DEPTH_LOG2=2.
// Inputs change on negedge; outputs are sampled on negedge after each posedge.
module tb_uart_tx_fifo;
    localparam int CPB = 4;
    localparam int DL2 = 2;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    logic [7:0] exp_q [$];

    uart_tx_fifo_if #(.DEPTH_LOG2(DL2)) bus ();

    uart_tx_fifo #(
        .CLKS_PER_BIT (CPB),
        .DEPTH_LOG2   (DL2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Sample k of a frame (k=0 is the cycle right after the pop edge):
    // 0..3 start bit, 4..35 data LSB first, 36..39 stop bit.
    task automatic check_frame(input logic [7:0] b, input int first_k);
        logic exp_bit;
        for (int k = first_k; k < 10 * CPB; k++) begin
            if (k > first_k) step();
            if (k < CPB)            exp_bit = 1'b0;
            else if (k < 9 * CPB)   exp_bit = b[(k - CPB) / CPB];
            else                    exp_bit = 1'b1;
            chk($sformatf("frame_%02h_k%0d", b, k), {31'd0, bus.tx}, {31'd0, exp_bit});
        end
    endtask

    // One idle-high cycle between frames, then the next start bit.
    task automatic next_frame(input logic [7:0] b);
        step();
        chk("gap_idle_tx", {31'd0, bus.tx}, 32'd1);
        step();
        check_frame(b, 0);
    endtask

    task automatic write_byte(input logic [7:0] b);
        bus.wr_en   = 1'b1;
        bus.wr_data = b;
        step();
        bus.wr_en   = 1'b0;
    endtask

    initial begin
        int  n;
        logic saw_low;
        logic [7:0] b;
        checks      = 0;
        failures    = 0;
        rst         = 1'b1;
        bus.wr_en   = 1'b0;
        bus.wr_data = 8'h00;
        bus.ovf_clr = 1'b0;

        // Reset state
        step();
        step();
        chk("rst_tx",       {31'd0, bus.tx},       32'd1);
        chk("rst_count",    {29'd0, bus.count},    32'd0);
        chk("rst_full",     {31'd0, bus.full},     32'd0);
        chk("rst_busy",     {31'd0, bus.busy},     32'd0);
        chk("rst_overflow", {31'd0, bus.overflow}, 32'd0);
        chk("rst_state",    {30'd0, bus.state_dbg}, 32'd0);
        rst = 1'b0;
        step();

        // Single byte 0x55
        write_byte(8'h55);
        chk("single_count_after_wr", {29'd0, bus.count}, 32'd1);
        chk("single_tx_after_wr",    {31'd0, bus.tx},    32'd1);
        chk("single_busy_after_wr",  {31'd0, bus.busy},  32'd1);
        step();
        chk("single_count_after_pop", {29'd0, bus.count}, 32'd0);
        check_frame(8'h55, 0);
        chk("single_busy_n40", {31'd0, bus.busy}, 32'd1);
        step();
        chk("single_busy_n41", {31'd0, bus.busy},     32'd0);
        chk("single_tx_n41",   {31'd0, bus.tx},       32'd1);
        chk("single_overflow", {31'd0, bus.overflow}, 32'd0);

        // Burst overflow: 0xA0 pops at N+1, 0xA1..0xA4 fill the FIFO, 0xA5 drops
        for (int i = 0; i < 6; i++) begin
            b = 8'hA0 + 8'(i);
            write_byte(b);
            if (i == 4) begin
                chk("burst_count_n4", {29'd0, bus.count},    32'd4);
                chk("burst_full_n4",  {31'd0, bus.full},     32'd1);
                chk("burst_ovf_n4",   {31'd0, bus.overflow}, 32'd0);
            end
        end
        chk("burst_ovf_n5",   {31'd0, bus.overflow}, 32'd1);
        chk("burst_count_n5", {29'd0, bus.count},    32'd4);
        check_frame(8'hA0, 4);
        for (int i = 1; i < 5; i++) next_frame(8'hA0 + 8'(i));
        step();
        chk("burst_busy_end",  {31'd0, bus.busy},     32'd0);
        chk("burst_count_end", {29'd0, bus.count},    32'd0);
        chk("burst_ovf_end",   {31'd0, bus.overflow}, 32'd1);

        // Overflow clear while not full
        bus.ovf_clr = 1'b1;
        step();
        bus.ovf_clr = 1'b0;
        chk("ovfclr_plain", {31'd0, bus.overflow}, 32'd0);

        // Clear and drop on the same edge: set wins
        for (int i = 0; i < 5; i++) write_byte(8'hB0 + 8'(i));
        chk("ovfclr_full_before", {31'd0, bus.full},     32'd1);
        chk("ovfclr_ovf_before",  {31'd0, bus.overflow}, 32'd0);
        bus.ovf_clr = 1'b1;
        write_byte(8'hB5);
        bus.ovf_clr = 1'b0;
        chk("ovfclr_set_wins", {31'd0, bus.overflow}, 32'd1);
        chk("ovfclr_count",    {29'd0, bus.count},    32'd4);
        n = 0;
        while (bus.busy && n < 400) begin
            step();
            n++;
        end
        chk("drain_within_budget", {31'd0, (n < 400)}, 32'd1);
        bus.ovf_clr = 1'b1;
        step();
        bus.ovf_clr = 1'b0;
        chk("ovfclr_after_drain", {31'd0, bus.overflow}, 32'd0);

        // Wrap-around: 0x00..0x03 up front, one more per inter-frame gap
        for (int i = 0; i < 4; i++) begin
            write_byte(8'(i));
            exp_q.push_back(8'(i));
        end
        chk("wrap_count_start", {29'd0, bus.count}, 32'd3);
        check_frame(exp_q.pop_front(), 2);
        for (int j = 1; j < 10; j++) begin
            if (j + 3 <= 9) begin
                write_byte(8'(j + 3));
                exp_q.push_back(8'(j + 3));
            end else begin
                step();
            end
            chk("wrap_gap_tx", {31'd0, bus.tx}, 32'd1);
            step();
            check_frame(exp_q.pop_front(), 0);
        end
        step();
        chk("wrap_queue_empty", exp_q.size(), 32'd0);
        chk("wrap_busy_end",    {31'd0, bus.busy},     32'd0);
        chk("wrap_overflow",    {31'd0, bus.overflow}, 32'd0);

        // Simultaneous pop and write
        write_byte(8'h81);
        chk("simul_count_before", {29'd0, bus.count}, 32'd1);
        write_byte(8'h7E);
        chk("simul_count_after", {29'd0, bus.count}, 32'd1);
        check_frame(8'h81, 0);
        next_frame(8'h7E);
        step();
        chk("simul_busy_end", {31'd0, bus.busy}, 32'd0);

        // Reset mid-frame, in DATA of 0x3C with 0xC3 queued
        write_byte(8'h3C);
        write_byte(8'hC3);
        for (int i = 0; i < 10; i++) step();
        chk("midrst_in_data",  {30'd0, bus.state_dbg}, 32'd2);
        chk("midrst_queued",   {29'd0, bus.count},     32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_tx",    {31'd0, bus.tx},        32'd1);
        chk("midrst_count", {29'd0, bus.count},     32'd0);
        chk("midrst_busy",  {31'd0, bus.busy},      32'd0);
        chk("midrst_state", {30'd0, bus.state_dbg}, 32'd0);
        saw_low = 1'b0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (bus.tx !== 1'b1) saw_low = 1'b1;
        end
        chk("midrst_line_quiet", {31'd0, saw_low}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
